// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers.
package pipe_pkg;

  // Default field widths for a MEM/WB-style stage.
  localparam int unsigned DEF_CTRL_W = 5;
  localparam int unsigned DEF_DATA_W = 96;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_CNT_W  = 16;

  // Control-bundle bit positions.
  localparam int unsigned CTRL_MEMTOREG = 0;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_SIZE_LO  = 2;
  localparam int unsigned CTRL_SIZE_HI  = 3;
  localparam int unsigned CTRL_LWSIG    = 4;

  // Stage occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of(state_e s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Single entry register: load, invalidate, and flush (clears valid and ctrl).
module pipe_slot #(
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  input  logic [REG_W-1:0]  d_wreg,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [REG_W-1:0]  q_wreg
);

  // Entry storage; flush keeps data/wreg but turns the slot into a bubble.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_data <= '0;
      q_wreg <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      q_ctrl <= d_ctrl;
      q_data <= d_data;
      q_wreg <= d_wreg;
    end else if (drop) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with 2-entry skid buffer, flush and stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W       = DEF_CTRL_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned REG_W        = DEF_REG_W,
  parameter int unsigned REGWRITE_BIT = CTRL_REGWRITE,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_wreg,
  output logic              out_regwrite,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e state, state_nxt;

  logic accept, drain, stall;
  logic main_load, main_from_skid, main_drop;
  logic skid_load, skid_drop, skid_valid;

  logic [CTRL_W-1:0] skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] skid_data, main_d_data;
  logic [REG_W-1:0]  skid_wreg, main_d_wreg;

  assign in_ready     = ~skid_valid;
  assign accept       = in_valid & in_ready;
  assign drain        = out_valid & out_ready;
  assign stall        = out_valid & ~out_ready;
  assign out_regwrite = out_valid & out_ctrl[REGWRITE_BIT];
  assign occupancy    = occ_of(state);

  // Main slot refills from skid when draining out of FULL, else from upstream.
  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_data;
  assign main_d_wreg = main_from_skid ? skid_wreg : in_wreg;

  // Occupancy state register.
  always_ff @(posedge CLOCK) begin
    if (RESET) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next-state and slot control; flush overrides any accept or drain.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_nxt = FULL;
        end else if (drain) begin
          main_drop = 1'b1;
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (FLUSH) begin
      state_nxt = EMPTY;
      main_load = 1'b0;
      main_drop = 1'b0;
      skid_load = 1'b0;
      skid_drop = 1'b0;
    end
  end

  // Saturating count of cycles the output was held back.
  always_ff @(posedge CLOCK) begin
    if (RESET)                          stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W)) u_main (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .clear  (FLUSH),
    .load   (main_load),
    .drop   (main_drop),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .d_wreg (main_d_wreg),
    .valid  (out_valid),
    .q_ctrl (out_ctrl),
    .q_data (out_data),
    .q_wreg (out_wreg)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W)) u_skid (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .clear  (FLUSH),
    .load   (skid_load),
    .drop   (skid_drop),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .d_wreg (in_wreg),
    .valid  (skid_valid),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data),
    .q_wreg (skid_wreg)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: FIFO reference model plus directed corners.
module tb_pipe_stage_elastic;

  localparam int unsigned CTRL_W  = 5;
  localparam int unsigned DATA_W  = 96;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  wreg;
  } ent_t;

  logic              CLOCK = 1'b0;
  logic              RESET, FLUSH, in_valid, in_ready, out_valid, out_ready, out_regwrite;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [REG_W-1:0]  in_wreg, out_wreg;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  ent_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_stall = 0;
  bit   push_now = 1'b0;
  bit   mon_en   = 1'b0;

  always #5 CLOCK = ~CLOCK;

  pipe_stage_elastic #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W), .REGWRITE_BIT(1), .CNT_W(CNT_W)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wreg(in_wreg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_wreg(out_wreg),
    .out_regwrite(out_regwrite), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.ctrl = CTRL_W'($urandom());
    e.data = {$urandom(), $urandom(), $urandom()};
    e.wreg = REG_W'($urandom());
    return e;
  endfunction

  // One cycle of stimulus; accepted entries go to the scoreboard.
  task automatic drive(input bit iv, input bit orr, input bit fl, input bit rs, input ent_t e);
    @(posedge CLOCK);
    #1;
    in_valid  = iv;
    out_ready = orr;
    FLUSH     = fl;
    RESET     = rs;
    in_ctrl   = e.ctrl;
    in_data   = e.data;
    in_wreg   = e.wreg;
    push_now  = iv && in_ready && !fl && !rs;
    if (push_now) exp_q.push_back(e);
  endtask

  // Monitor: compare the presented entry and status against the FIFO model.
  initial begin
    int held;
    wait (mon_en);
    forever begin
      @(negedge CLOCK);
      held = exp_q.size() - int'(push_now);
      check("occupancy", 128'(occupancy), 128'(held));
      check("out_valid", 128'(out_valid), 128'(held > 0));
      check("in_ready",  128'(in_ready),  128'(held < 2));
      check("stall_cnt", 128'(stall_cnt), 128'(model_stall));
      if (held > 0) begin
        check("out_ctrl", 128'(out_ctrl), 128'(exp_q[0].ctrl));
        check("out_data", 128'(out_data), 128'(exp_q[0].data));
        check("out_wreg", 128'(out_wreg), 128'(exp_q[0].wreg));
        check("out_regwrite", 128'(out_regwrite), 128'(exp_q[0].ctrl[1]));
      end else begin
        check("out_regwrite_idle", 128'(out_regwrite), 128'(0));
      end
      if (RESET) begin
        exp_q.delete();
        model_stall = 0;
      end else begin
        if (held > 0 && out_ready)  void'(exp_q.pop_front());
        if (held > 0 && !out_ready && model_stall < CNT_MAX) model_stall++;
        if (FLUSH) exp_q.delete();
      end
    end
  end

  // Stimulus: directed scenarios then a randomized soak.
  initial begin
    ent_t z, e, a, b;
    z = '0;
    RESET = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0; in_wreg = '0;
    @(posedge CLOCK);
    #1 mon_en = 1'b1;
    drive(0, 0, 0, 1, z);
    drive(0, 0, 0, 0, z);
    @(negedge CLOCK);
    check("rst_ctrl", 128'(out_ctrl), 128'(0));
    check("rst_data", 128'(out_data), 128'(0));
    check("rst_wreg", 128'(out_wreg), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Back-to-back streaming with wreg/data = 1..8.
    for (int i = 1; i <= 8; i++) begin
      e.ctrl = 5'b00010; e.data = DATA_W'(i); e.wreg = REG_W'(i);
      drive(1, 1, 0, 0, e);
    end
    drive(0, 1, 0, 0, z);
    drive(0, 1, 0, 0, z);

    // Fill to FULL under backpressure, then release.
    a = rand_ent(); b = rand_ent();
    drive(1, 0, 0, 0, a);
    drive(1, 0, 0, 0, b);
    repeat (3) drive(0, 0, 0, 0, z);
    @(negedge CLOCK);
    check("full_occ", 128'(occupancy), 128'(2));
    check("full_in_ready", 128'(in_ready), 128'(0));
    check("full_head_wreg", 128'(out_wreg), 128'(a.wreg));
    repeat (3) drive(0, 1, 0, 0, z);

    // Flush while FULL with a same-cycle incoming entry.
    drive(1, 0, 0, 0, rand_ent());
    drive(1, 0, 0, 0, rand_ent());
    e = rand_ent(); e.ctrl = 5'b11111;
    drive(1, 0, 1, 0, e);
    drive(0, 0, 0, 0, z);
    @(negedge CLOCK);
    check("flush_occ", 128'(occupancy), 128'(0));
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_regwrite", 128'(out_regwrite), 128'(0));
    check("flush_ctrl", 128'(out_ctrl), 128'(0));
    repeat (2) drive(0, 1, 0, 0, z);

    // Stall counter saturation; survives flush, cleared by reset.
    drive(1, 0, 0, 0, rand_ent());
    repeat (20) drive(0, 0, 0, 0, z);
    @(negedge CLOCK);
    check("stall_sat", 128'(stall_cnt), 128'(CNT_MAX));
    drive(0, 0, 1, 0, z);
    drive(0, 1, 0, 0, z);
    @(negedge CLOCK);
    check("stall_after_flush", 128'(stall_cnt), 128'(CNT_MAX));
    drive(0, 0, 0, 1, z);
    drive(0, 0, 0, 0, z);
    @(negedge CLOCK);
    check("stall_after_reset", 128'(stall_cnt), 128'(0));

    // Reset while FULL, then a fresh entry.
    drive(1, 0, 0, 0, rand_ent());
    drive(1, 0, 0, 0, rand_ent());
    drive(0, 0, 0, 0, z);
    drive(1, 1, 0, 1, rand_ent());
    drive(0, 0, 0, 0, z);
    @(negedge CLOCK);
    check("midrst_valid", 128'(out_valid), 128'(0));
    check("midrst_ready", 128'(in_ready), 128'(1));
    check("midrst_data", 128'(out_data), 128'(0));
    e = rand_ent();
    drive(1, 0, 0, 0, e);
    drive(0, 0, 0, 0, z);
    @(negedge CLOCK);
    check("post_rst_latency", 128'(out_valid), 128'(1));
    check("post_rst_data", 128'(out_data), 128'(e.data));
    drive(0, 1, 0, 0, z);

    // Randomized soak with varying traffic and pressure.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 47) == 0, $urandom_range(0, 299) == 0, rand_ent());
    end
    repeat (4) drive(0, 1, 0, 0, z);
    @(negedge CLOCK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
